ecliptic_fp_misc: RTL and testbench
===================================

# ecliptic_fp_misc

Single-precision (IEEE-754 binary32) miscellaneous-operation unit of the ecliptic FPU. It covers the non-arithmetic RISC-V F instructions: sign injection (FSGNJ/FSGNJN/FSGNJX), classification (FCLASS.S), and comparison/min-max (FEQ/FLT/FLE/FMIN/FMAX). It sits beside the arithmetic pipes and returns a 32-bit result plus an invalid flag one cycle after a request.

## Interface

Parameters:
- none.

Ports:
- `clk` in 1: clock. One clock domain; all logic on rising edge.
- `nrst` in 1: reset. Synchronous, active-high.
- `req` in 1: request valid. Operands are sampled on every cycle where `req`=1.
- `fn` in 2: unit select. 00 = bit operation, 01 = classification, 10 = comparison, 11 = reserved.
- `op` in 3: operation within the unit.
  - Bit operation uses `op[1:0]`: 00 FSGNJ, 01 FSGNJN, 10 FSGNJX, 11 = FSGNJ.
  - Comparison: 000 FLE, 001 FLT, 010 FEQ, 100 FMIN, 101 FMAX; other codes give `res`=0 and `invalid`=0.
- `src1` in 32: operand A.
- `src2` in 32: operand B. Ignored for classification.
- `ack` out 1: result valid, one cycle after `req`.
- `res` out 32: result.
- `invalid` out 1: IEEE invalid-operation flag. Valid with `ack`; 0 except for comparison.

## Operation

Operand decode: exp = [30:23], man = [22:0].
- Zero: exp=0, man=0.
- Subnormal: exp=0, man≠0.
- Inf: exp=FF, man=0.
- NaN: exp=FF, man≠0.
- qNaN: NaN with man[22]=1. sNaN: NaN with man[22]=0.

Bit operation:
- `res` = {s, src1[30:0]}.
- s = src2[31] for FSGNJ, ~src2[31] for FSGNJN, src1[31]^src2[31] for FSGNJX.
- No NaN special-casing.

Classification:
- `res[9:0]` is one-hot: bit9 qNaN, bit8 sNaN, bit7 +inf, bit6 +normal, bit5 +subnormal, bit4 +0, bit3 −0, bit2 −subnormal, bit1 −normal, bit0 −inf.
- `res[31:10]`=0.

Comparison:
- FEQ/FLT/FLE produce `res` = 32'h1 if the relation holds, else 0.
  - +0 and −0 compare equal.
  - Ordering is by sign-magnitude; subnormals compare normally.
  - Any NaN operand gives `res`=0.
- Invalid flag:
  - FEQ is quiet: `invalid`=1 only if an operand is an sNaN.
  - FLT and FLE are signaling: `invalid`=1 if any operand is a NaN.
- FMIN/FMAX:
  - Return the smaller/larger operand bit pattern; −0 is treated as less than +0.
  - Exactly one operand NaN: return the other operand.
  - Both operands NaN: return canonical qNaN 32'h7fc00000.
  - `invalid`=1 if any operand is an sNaN.

## Timing

- Latency 1 cycle. `ack`, `res` and `invalid` are registered: `ack` at cycle N+1 equals `req` at cycle N.
- Fully pipelined, throughput 1 per cycle. No backpressure; `ack` cannot be stalled.
- `res`/`invalid` update only when `req`=1. With `req`=0 they hold their previous values and `ack`=0.
- Reset values (`nrst`=1 at an edge): `ack`=0, `res`=0, `invalid`=0.
- Reset has priority over `req`. A request sampled in the same cycle as reset is dropped.
- No state beyond the output registers. Operations are independent; a reset mid-stream loses only the in-flight result.

## Structure

- Shared package `ecliptic_pkg` holds:
  - the `fn` and `op` encodings as localparams;
  - the class-result packed struct (qNaN..nInf, MSB first);
  - the canonical NaN constant 32'h7fc00000;
  - an operand-decode function returning zero/subnormal/inf/qNaN/sNaN/sign flags.
- Three sub-modules (`ecliptic_bitoperation`, `ecliptic_classification`, `ecliptic_comparison`). Each has its own clk/nrst/req/ack and a registered result.
- The top level fans out `req` by `fn` and muxes the registered outputs using a registered copy of `fn`.

## Test plan

- FMAX (fn=10, op=101), src1=3f800000, src2=cf800000 → `res`=3f800000, `invalid`=0, `ack` one cycle after `req`.
- FMAX, src1=7f800001 (sNaN), src2=3f800000 → `res`=3f800000, `invalid`=1. Same operands with FEQ → `res`=0, `invalid`=1.
- Classification of 3f800000, 7f800001, 00000003, ff800000, 80000000 → `res` = 040, 100, 020, 001, 008 (hex).
- FSGNJ src1=3f800000, src2=cf800000 → bf800000. FSGNJN with the same operands → 3f800000. FSGNJX src1=bf800000, src2=cf800000 → 3f800000.
- FMIN src1=00000000, src2=80000000 → 80000000. FMIN with both operands qNaN → 7fc00000. FLE 0 vs −0 → 1. FLT with one operand 7fc00000 → `res`=0, `invalid`=1.
- Assert `nrst` while `req`=1 with back-to-back ops → outputs are 0 the cycle after reset; after release, results resume with 1-cycle latency and throughput of 1 per cycle.

Source files
------------

// File: rtl/ecliptic_pkg.sv
// Shared encodings, result structs and operand decode for the ecliptic
// miscellaneous-operation unit.
package ecliptic_pkg;

  // Unit select
  localparam logic [1:0] FN_BIT   = 2'b00;
  localparam logic [1:0] FN_CLASS = 2'b01;
  localparam logic [1:0] FN_CMP   = 2'b10;
  localparam logic [1:0] FN_RSV   = 2'b11;

  // Sign-injection operations (op[1:0]); 2'b11 aliases FSGNJ
  localparam logic [1:0] OP_FSGNJ  = 2'b00;
  localparam logic [1:0] OP_FSGNJN = 2'b01;
  localparam logic [1:0] OP_FSGNJX = 2'b10;

  // Comparison operations
  localparam logic [2:0] OP_FLE  = 3'b000;
  localparam logic [2:0] OP_FLT  = 3'b001;
  localparam logic [2:0] OP_FEQ  = 3'b010;
  localparam logic [2:0] OP_FMIN = 3'b100;
  localparam logic [2:0] OP_FMAX = 3'b101;

  localparam logic [31:0] CANON_NAN = 32'h7fc0_0000;

  // FCLASS one-hot result, MSB first
  typedef struct packed {
    logic qnan;
    logic snan;
    logic pinf;
    logic pnorm;
    logic psub;
    logic pzero;
    logic nzero;
    logic nsub;
    logic nnorm;
    logic ninf;
  } class_t;

  typedef struct packed {
    logic sign;
    logic zero;
    logic subnormal;
    logic inf;
    logic qnan;
    logic snan;
  } operand_t;

  function automatic operand_t decode(input logic [31:0] x);
    operand_t d;
    logic     exp_zero;
    logic     exp_ones;
    logic     man_zero;
    exp_zero    = (x[30:23] == 8'h00);
    exp_ones    = (x[30:23] == 8'hff);
    man_zero    = (x[22:0] == 23'd0);
    d.sign      = x[31];
    d.zero      = exp_zero & man_zero;
    d.subnormal = exp_zero & ~man_zero;
    d.inf       = exp_ones & man_zero;
    d.qnan      = exp_ones & ~man_zero & x[22];
    d.snan      = exp_ones & ~man_zero & ~x[22];
    return d;
  endfunction

endpackage

// File: rtl/ecliptic_fp_misc_if.sv
// Request/response bundle between the FPU issue logic and the misc unit.
interface ecliptic_fp_misc_if;
  logic        req;
  logic [1:0]  fn;
  logic [2:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        ack;
  logic [31:0] res;
  logic        invalid;

  modport master (output req, fn, op, src1, src2, input ack, res, invalid);
  modport slave  (input req, fn, op, src1, src2, output ack, res, invalid);
endinterface

// File: rtl/ecliptic_bitoperation.sv
// Sign injection (FSGNJ/FSGNJN/FSGNJX) with a registered result.
module ecliptic_bitoperation
  import ecliptic_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        req,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        ack,
  output logic [31:0] res
);

  logic sign;

  // Pick the injected sign bit
  always_comb begin
    // NOTE: every path assigns 'sign' (the default arm covers 2'b11), so no latch is inferred.
    case (op)
      OP_FSGNJN: sign = ~src2[31];
      OP_FSGNJX: sign = src1[31] ^ src2[31];
      default:   sign = src2[31];
    endcase
  end

  // Register the result; hold it while idle
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (nrst) begin
      ack <= 1'b0;
      res <= '0;
    end else begin
      ack <= req;
      if (req) res <= {sign, src1[30:0]};
    end
  end

endmodule

// File: rtl/ecliptic_classification.sv
// FCLASS.S: one-hot classification of src1, registered.
module ecliptic_classification
  import ecliptic_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        req,
  input  logic [31:0] src1,
  output logic        ack,
  output class_t      res
);

  operand_t d;
  class_t   cls;
  logic     normal;

  // Decode the operand into its IEEE class
  always_comb begin
    d          = decode(src1);
    normal     = ~(d.zero | d.subnormal | d.inf | d.qnan | d.snan);
    cls.qnan   = d.qnan;
    cls.snan   = d.snan;
    cls.pinf   = ~d.sign & d.inf;
    cls.pnorm  = ~d.sign & normal;
    cls.psub   = ~d.sign & d.subnormal;
    cls.pzero  = ~d.sign & d.zero;
    cls.nzero  =  d.sign & d.zero;
    cls.nsub   =  d.sign & d.subnormal;
    cls.nnorm  =  d.sign & normal;
    cls.ninf   =  d.sign & d.inf;
  end

  // Register the class vector; hold it while idle
  always_ff @(posedge clk) begin
    if (nrst) begin
      ack <= 1'b0;
      res <= '0;
    end else begin
      ack <= req;
      if (req) res <= cls;
    end
  end

endmodule

// File: rtl/ecliptic_comparison.sv
// FEQ/FLT/FLE and FMIN/FMAX with the IEEE invalid flag, registered.
module ecliptic_comparison
  import ecliptic_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        ack,
  output logic [31:0] res,
  output logic        invalid
);

  operand_t da, db;
  logic     nan_a, nan_b, nan_any, snan_any;
  logic     a_less, eq, lt;
  logic [31:0] res_d;
  logic        inv_d;

  // Sign-magnitude ordering plus NaN handling for every comparison op
  always_comb begin
    da       = decode(src1);
    db       = decode(src2);
    nan_a    = da.qnan | da.snan;
    nan_b    = db.qnan | db.snan;
    nan_any  = nan_a | nan_b;
    snan_any = da.snan | db.snan;
    // Total order on the bit patterns: -0 sorts below +0 here
    if (da.sign != db.sign) a_less = da.sign;
    else if (da.sign)       a_less = src1[30:0] > src2[30:0];
    else                    a_less = src1[30:0] < src2[30:0];
    eq = ~nan_any & ((src1 == src2) | (da.zero & db.zero));
    lt = ~nan_any & ~eq & a_less;

    res_d = '0;
    inv_d = 1'b0;
    case (op)
      OP_FEQ: begin res_d = {31'd0, eq};       inv_d = snan_any; end
      OP_FLT: begin res_d = {31'd0, lt};       inv_d = nan_any;  end
      OP_FLE: begin res_d = {31'd0, lt | eq};  inv_d = nan_any;  end
      OP_FMIN, OP_FMAX: begin
        inv_d = snan_any;
        if (nan_a & nan_b) res_d = CANON_NAN;
        else if (nan_a)    res_d = src2;
        else if (nan_b)    res_d = src1;
        else if (op == OP_FMIN) res_d = a_less ? src1 : src2;
        else                    res_d = a_less ? src2 : src1;
      end
      default: ;
    endcase
  end

  // Register result and flag; hold them while idle
  always_ff @(posedge clk) begin
    if (nrst) begin
      ack     <= 1'b0;
      res     <= '0;
      invalid <= 1'b0;
    end else begin
      ack <= req;
      if (req) begin
        res     <= res_d;
        invalid <= inv_d;
      end
    end
  end

endmodule

// File: rtl/ecliptic_fp_misc.sv
// Top of the misc unit: steers each request to one sub-unit and muxes the
// registered results back using the function code captured with the request.
module ecliptic_fp_misc
  import ecliptic_pkg::*;
(
  input  logic                clk,
  input  logic                nrst,
  ecliptic_fp_misc_if.slave   bus
);

  logic        req_bit, req_cls, req_cmp;
  logic        ack_bit, ack_cls, ack_cmp, ack_rsv;
  logic [31:0] res_bit, res_cmp;
  class_t      res_cls;
  logic        inv_cmp;
  logic [1:0]  fn_q;

  assign req_bit = bus.req & (bus.fn == FN_BIT);
  assign req_cls = bus.req & (bus.fn == FN_CLASS);
  assign req_cmp = bus.req & (bus.fn == FN_CMP);

  ecliptic_bitoperation u_bit (
    .clk(clk), .nrst(nrst), .req(req_bit), .op(bus.op[1:0]),
    .src1(bus.src1), .src2(bus.src2), .ack(ack_bit), .res(res_bit)
  );

  ecliptic_classification u_cls (
    .clk(clk), .nrst(nrst), .req(req_cls), .src1(bus.src1),
    .ack(ack_cls), .res(res_cls)
  );

  ecliptic_comparison u_cmp (
    .clk(clk), .nrst(nrst), .req(req_cmp), .op(bus.op),
    .src1(bus.src1), .src2(bus.src2), .ack(ack_cmp), .res(res_cmp),
    .invalid(inv_cmp)
  );

  // Remember which unit owns the visible result; reserved fn still acks
  always_ff @(posedge clk) begin
    if (nrst) begin
      fn_q    <= FN_BIT;
      ack_rsv <= 1'b0;
    end else begin
      ack_rsv <= bus.req & (bus.fn == FN_RSV);
      if (bus.req) fn_q <= bus.fn;
    end
  end

  assign bus.ack = ack_bit | ack_cls | ack_cmp | ack_rsv;

  // Select the registered result of the unit that served the last request
  always_comb begin
    bus.res     = '0;
    bus.invalid = 1'b0;
    case (fn_q)
      FN_BIT:   bus.res = res_bit;
      FN_CLASS: bus.res = {22'd0, res_cls};
      FN_CMP: begin
        bus.res     = res_cmp;
        bus.invalid = inv_cmp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ecliptic_fp_misc.sv
// Directed self-checking bench for ecliptic_fp_misc.
module tb_ecliptic_fp_misc;
  import ecliptic_pkg::*;

  logic clk = 1'b0;
  logic nrst;
  int   tests = 0;
  int   failed = 0;

  ecliptic_fp_misc_if bus ();

  ecliptic_fp_misc dut (.clk(clk), .nrst(nrst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request at the falling edge, then look just after the rising edge.
  task automatic issue(input logic [1:0] fn, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.req  = 1'b1;
    bus.fn   = fn;
    bus.op   = op;
    bus.src1 = a;
    bus.src2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] res, input logic inv);
    check({tag, ".ack"}, {31'd0, bus.ack}, 32'd1);
    check({tag, ".res"}, bus.res, res);
    check({tag, ".inv"}, {31'd0, bus.invalid}, {31'd0, inv});
  endtask

  initial begin
    nrst     = 1'b1;
    bus.req  = 1'b0;
    bus.fn   = 2'b00;
    bus.op   = 3'b000;
    bus.src1 = '0;
    bus.src2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.ack", {31'd0, bus.ack}, 32'd0);
    check("reset.res", bus.res, 32'd0);
    check("reset.inv", {31'd0, bus.invalid}, 32'd0);
    @(negedge clk);
    nrst = 1'b0;

    // FMAX basic and one-cycle latency
    issue(FN_CMP, OP_FMAX, 32'h3f800000, 32'hcf800000);
    expect_out("fmax", 32'h3f800000, 1'b0);
    idle();
    check("idle.ack", {31'd0, bus.ack}, 32'd0);
    check("idle.hold", bus.res, 32'h3f800000);

    // sNaN handling
    issue(FN_CMP, OP_FMAX, 32'h7f800001, 32'h3f800000);
    expect_out("fmax_snan", 32'h3f800000, 1'b1);
    issue(FN_CMP, OP_FEQ, 32'h7f800001, 32'h3f800000);
    expect_out("feq_snan", 32'h0, 1'b1);
    issue(FN_CMP, OP_FEQ, 32'h7fc00000, 32'h7fc00000);
    expect_out("feq_qnan", 32'h0, 1'b0);

    // Classification
    issue(FN_CLASS, 3'b000, 32'h3f800000, 32'hffffffff);
    expect_out("class_pnorm", 32'h040, 1'b0);
    issue(FN_CLASS, 3'b000, 32'h7f800001, 32'h0);
    expect_out("class_snan", 32'h100, 1'b0);
    issue(FN_CLASS, 3'b000, 32'h00000003, 32'h0);
    expect_out("class_psub", 32'h020, 1'b0);
    issue(FN_CLASS, 3'b000, 32'hff800000, 32'h0);
    expect_out("class_ninf", 32'h001, 1'b0);
    issue(FN_CLASS, 3'b000, 32'h80000000, 32'h0);
    expect_out("class_nzero", 32'h008, 1'b0);
    issue(FN_CLASS, 3'b000, 32'h7fc00000, 32'h0);
    expect_out("class_qnan", 32'h200, 1'b0);

    // Sign injection
    issue(FN_BIT, {1'b0, OP_FSGNJ}, 32'h3f800000, 32'hcf800000);
    expect_out("fsgnj", 32'hbf800000, 1'b0);
    issue(FN_BIT, {1'b0, OP_FSGNJN}, 32'h3f800000, 32'hcf800000);
    expect_out("fsgnjn", 32'h3f800000, 1'b0);
    issue(FN_BIT, {1'b0, OP_FSGNJX}, 32'hbf800000, 32'hcf800000);
    expect_out("fsgnjx", 32'h3f800000, 1'b0);
    issue(FN_BIT, 3'b011, 32'h3f800000, 32'hcf800000);
    expect_out("fsgnj_alias", 32'hbf800000, 1'b0);

    // Comparison boundaries
    issue(FN_CMP, OP_FMIN, 32'h00000000, 32'h80000000);
    expect_out("fmin_zero", 32'h80000000, 1'b0);
    issue(FN_CMP, OP_FMAX, 32'h80000000, 32'h00000000);
    expect_out("fmax_zero", 32'h00000000, 1'b0);
    issue(FN_CMP, OP_FMIN, 32'h7fc00000, 32'hffc00001);
    expect_out("fmin_2nan", 32'h7fc00000, 1'b0);
    issue(FN_CMP, OP_FMIN, 32'h7fc00000, 32'hc0000000);
    expect_out("fmin_1nan", 32'hc0000000, 1'b0);
    issue(FN_CMP, OP_FLE, 32'h00000000, 32'h80000000);
    expect_out("fle_zeros", 32'h1, 1'b0);
    issue(FN_CMP, OP_FLT, 32'h00000000, 32'h80000000);
    expect_out("flt_zeros", 32'h0, 1'b0);
    issue(FN_CMP, OP_FLT, 32'h7fc00000, 32'h3f800000);
    expect_out("flt_qnan", 32'h0, 1'b1);
    issue(FN_CMP, OP_FLT, 32'hc0000000, 32'hbf800000);
    expect_out("flt_neg", 32'h1, 1'b0);
    issue(FN_CMP, OP_FLT, 32'hbf800000, 32'hc0000000);
    expect_out("flt_neg_rev", 32'h0, 1'b0);
    issue(FN_CMP, OP_FLT, 32'h00000001, 32'h00000002);
    expect_out("flt_sub", 32'h1, 1'b0);
    issue(FN_CMP, OP_FEQ, 32'h80000000, 32'h00000000);
    expect_out("feq_zeros", 32'h1, 1'b0);
    issue(FN_CMP, 3'b011, 32'h3f800000, 32'h3f800000);
    expect_out("cmp_rsv_op", 32'h0, 1'b0);

    // Reset in the middle of back-to-back traffic
    issue(FN_BIT, {1'b0, OP_FSGNJ}, 32'h3f800000, 32'hcf800000);
    expect_out("pre_rst", 32'hbf800000, 1'b0);
    @(negedge clk);
    nrst     = 1'b1;
    bus.req  = 1'b1;
    bus.fn   = FN_CMP;
    bus.op   = OP_FLT;
    bus.src1 = 32'h7fc00000;
    bus.src2 = 32'h0;
    @(posedge clk);
    #1;
    check("rst.ack", {31'd0, bus.ack}, 32'd0);
    check("rst.res", bus.res, 32'd0);
    check("rst.inv", {31'd0, bus.invalid}, 32'd0);
    @(negedge clk);
    nrst = 1'b0;
    issue(FN_BIT, {1'b0, OP_FSGNJN}, 32'h3f800000, 32'hcf800000);
    expect_out("b2b0", 32'h3f800000, 1'b0);
    issue(FN_CLASS, 3'b000, 32'h3f800000, 32'h0);
    expect_out("b2b1", 32'h040, 1'b0);
    issue(FN_CMP, OP_FLT, 32'h7f800001, 32'h3f800000);
    expect_out("b2b2", 32'h0, 1'b1);
    idle();
    check("end.ack", {31'd0, bus.ack}, 32'd0);
    check("end.inv", {31'd0, bus.invalid}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
